// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single backing-memory port between I-cache refills and D-cache refill/writeback bursts.
// Build option ARB_ROUND_ROBIN_EN: alternate grants on simultaneous requests; otherwise D has fixed priority.
module mem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_rvalid,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_wready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_rvalid,
  output logic              d_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              cache_busy
);

  localparam int CNT_W      = $clog2(BURST_LEN);
  localparam int LINE_BYTES = BURST_LEN * 4;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, I_BURST, D_BURST} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] beat_off;
  logic              we_lat;
  logic              last_grant;   // 0 = I served last, 1 = D served last
  logic              last_beat;
  logic              grant_i, grant_d;
  logic              tie_pick_i;

  logic [DATA_W-1:0] i_rdata_p1, d_rdata_p1;
  logic              i_vld_p1, d_vld_p1;
  logic              i_done_p1, d_done_p1;

  function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] a);
    return a & ~ADDR_W'(LINE_BYTES - 1);
  endfunction

  assign last_beat  = mem_ready && (cnt == CNT_W'(BURST_LEN - 1));
  assign beat_off   = ADDR_W'(cnt) << 2;
  assign tie_pick_i = RR_EN & ~last_grant ? 1'b0 : RR_EN & last_grant;

  // Grants are withheld while a done pulse is out so the finished requester can drop req.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state == IDLE && !(i_done_p1 || d_done_p1)) begin
      if (i_req && d_req) begin
        grant_i = tie_pick_i;
        grant_d = ~tie_pick_i;
      end else begin
        grant_i = i_req;
        grant_d = d_req;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_d)      state_nxt = D_BURST;
        else if (grant_i) state_nxt = I_BURST;
      end
      I_BURST, D_BURST: if (last_beat) state_nxt = IDLE;
      default:          state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    d_wready  = 1'b0;
    case (state)
      I_BURST: begin
        mem_req  = 1'b1;
        mem_addr = base_addr + beat_off;
      end
      D_BURST: begin
        mem_req  = 1'b1;
        mem_we   = we_lat;
        mem_addr = base_addr + beat_off;
        if (we_lat) begin
          mem_wdata = d_wdata;
          d_wready  = mem_ready;
        end
      end
      default: ;
    endcase
  end

  assign cache_busy = rst_n & ((state != IDLE) | i_req | d_req);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      base_addr  <= '0;
      we_lat     <= 1'b0;
      last_grant <= 1'b0;
    end else if (state == IDLE) begin
      if (grant_i || grant_d) begin
        cnt       <= '0;
        base_addr <= line_base(grant_d ? d_addr : i_addr);
        we_lat    <= grant_d & d_we;
      end
    end else if (mem_ready) begin
      cnt <= last_beat ? '0 : cnt + 1'b1;
      if (last_beat) last_grant <= (state == D_BURST);
    end
  end

  // p1: read beats and done pulses appear one cycle after the completing mem_ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_rdata_p1 <= '0;
      d_rdata_p1 <= '0;
      i_vld_p1   <= 1'b0;
      d_vld_p1   <= 1'b0;
      i_done_p1  <= 1'b0;
      d_done_p1  <= 1'b0;
    end else begin
      i_vld_p1  <= (state == I_BURST) & mem_ready;
      d_vld_p1  <= (state == D_BURST) & ~we_lat & mem_ready;
      i_done_p1 <= (state == I_BURST) & last_beat;
      d_done_p1 <= (state == D_BURST) & last_beat;
      if ((state == I_BURST) && mem_ready)            i_rdata_p1 <= mem_rdata;
      if ((state == D_BURST) && !we_lat && mem_ready) d_rdata_p1 <= mem_rdata;
    end
  end

  assign i_rdata  = i_rdata_p1;
  assign i_rvalid = i_vld_p1;
  assign i_done   = i_done_p1;
  assign d_rdata  = d_rdata_p1;
  assign d_rvalid = d_vld_p1;
  assign d_done   = d_done_p1;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized scoreboard bench for mem_arbiter with a line-level reference model.
module tb_mem_arbiter;
  localparam int ADDR_W = 32, DATA_W = 32, BL = 4;

  logic              clk = 1'b0, rst_n = 1'b0;
  logic              i_req, d_req, d_we, mem_ready;
  logic [ADDR_W-1:0] i_addr, d_addr, mem_addr;
  logic [DATA_W-1:0] i_rdata, d_rdata, d_wdata, mem_wdata, mem_rdata;
  logic              i_rvalid, i_done, d_wready, d_rvalid, d_done;
  logic              mem_req, mem_we, cache_busy;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BL)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wready(d_wready),
    .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_done(d_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .cache_busy(cache_busy)
  );

  typedef struct { logic [31:0] data; logic last; } rd_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; logic last; } wr_t;
  typedef struct { logic [31:0] addr; logic we; } dcmd_t;

  rd_t          i_exp[$], d_exp[$];
  wr_t          w_exp[$];
  logic [31:0]  i_cmd[$];
  dcmd_t        d_cmd[$];
  byte          order_exp[$];

  int n_cmp = 0, n_bad = 0;
  int i_done_cnt = 0, d_done_cnt = 0, d_wr_cnt = 0;
  int rdy_mode = 0;  // 0: always ready, 1: random, 2: alternate, 3: held low
  logic prev_rd = 1'b0, prev_done = 1'b0, wdone_due = 1'b0;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction
  function automatic logic [31:0] wr_f(input logic [31:0] base, input int k);
    return {base[31:8], 8'(k)} ^ 32'hDEAD_0000;
  endfunction
  function automatic logic [31:0] line_of(input logic [31:0] a);
    return a & ~32'(BL * 4 - 1);
  endfunction

  assign mem_rdata = mem_f(mem_addr);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_reads(input logic is_i, input logic [31:0] base);
    rd_t e;
    for (int k = 0; k < BL; k++) begin
      e.data = mem_f(base + 32'(4 * k));
      e.last = (k == BL - 1);
      if (is_i) i_exp.push_back(e);
      else      d_exp.push_back(e);
    end
  endtask

  // memory readiness
  initial begin
    mem_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       mem_ready = 1'b1;
        1:       mem_ready = 1'($urandom_range(0, 1));
        2:       mem_ready = ~mem_ready;
        default: mem_ready = 1'b0;
      endcase
    end
  end

  // I-cache requester
  initial begin : i_requester
    int used;
    used = 0;
    i_req = 1'b0; i_addr = '0;
    forever begin
      @(posedge clk); #1;
      if (i_req && used != i_done_cnt) begin
        used = i_done_cnt;
        if (i_cmd.size() > 0) begin
          i_addr = i_cmd.pop_front();
          push_reads(1'b1, line_of(i_addr));
        end else i_req = 1'b0;
      end else if (!i_req && i_cmd.size() > 0 && rst_n) begin
        used = i_done_cnt;
        i_addr = i_cmd.pop_front();
        i_req = 1'b1;
        push_reads(1'b1, line_of(i_addr));
      end
    end
  end

  // D-cache requester
  initial begin : d_requester
    int used, wr_used, beat;
    logic [31:0] base;
    dcmd_t c;
    wr_t w;
    used = 0; wr_used = 0; beat = 0; base = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    forever begin
      @(posedge clk); #1;
      if (wr_used != d_wr_cnt) begin
        beat += d_wr_cnt - wr_used;
        wr_used = d_wr_cnt;
        d_wdata = wr_f(base, beat);
      end
      if ((d_req && used != d_done_cnt) || (!d_req && d_cmd.size() > 0 && rst_n)) begin
        used = d_done_cnt;
        if (d_cmd.size() > 0) begin
          c = d_cmd.pop_front();
          d_req = 1'b1; d_addr = c.addr; d_we = c.we;
          base = line_of(c.addr); beat = 0;
          if (c.we) begin
            d_wdata = wr_f(base, 0);
            for (int k = 0; k < BL; k++) begin
              w.addr = base + 32'(4 * k); w.data = wr_f(base, k); w.last = (k == BL - 1);
              w_exp.push_back(w);
            end
          end else begin
            d_wdata = $urandom;
            push_reads(1'b0, base);
          end
        end else d_req = 1'b0;
      end
    end
  end

  // monitor / scoreboard
  initial begin : monitor
    rd_t  re;
    wr_t  we_e;
    logic wdone_next;
    byte  ord;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_rd = 1'b0; prev_done = 1'b0; wdone_due = 1'b0;
      end else begin
        wdone_next = 1'b0;
        if (prev_rd || i_rvalid || d_rvalid)
          check("rvalid_latency", 64'(i_rvalid | d_rvalid), 64'(prev_rd));
        if (prev_done) check("bubble_mem_req", 64'(mem_req), 64'd0);
        check("cache_busy", 64'(cache_busy), 64'(mem_req | i_req | d_req));
        if (i_rvalid) begin
          if (i_exp.size() == 0) check("i_rvalid_unexpected", 64'd1, 64'd0);
          else begin
            re = i_exp.pop_front();
            check("i_rdata", 64'(i_rdata), 64'(re.data));
            check("i_done", 64'(i_done), 64'(re.last));
          end
        end else if (i_done) check("i_done_alone", 64'd1, 64'd0);
        if (d_rvalid) begin
          if (d_exp.size() == 0) check("d_rvalid_unexpected", 64'd1, 64'd0);
          else begin
            re = d_exp.pop_front();
            check("d_rdata", 64'(d_rdata), 64'(re.data));
            check("d_done", 64'(d_done), 64'(re.last));
          end
        end else if (d_done || wdone_due) check("d_done_write", 64'(d_done), 64'(wdone_due));
        if (d_wready) begin
          if (w_exp.size() == 0) check("d_wready_unexpected", 64'd1, 64'd0);
          else begin
            we_e = w_exp.pop_front();
            check("w_addr", 64'(mem_addr), 64'(we_e.addr));
            check("w_data", 64'(mem_wdata), 64'(we_e.data));
            check("w_mem_we", 64'(mem_we), 64'd1);
            wdone_next = we_e.last;
          end
          d_wr_cnt++;
        end
        if (mem_req && mem_we) check("mem_wdata_pass", 64'(mem_wdata), 64'(d_wdata));
        if ((i_done || d_done) && order_exp.size() > 0) begin
          ord = order_exp.pop_front();
          check("grant_order", 64'(d_done ? 8'h44 : 8'h49), 64'(ord));
        end
        if (i_done) i_done_cnt++;
        if (d_done) d_done_cnt++;
        prev_rd   = mem_req & mem_ready & ~mem_we;
        prev_done = i_done | d_done;
        wdone_due = wdone_next;
      end
    end
  end

  task automatic check_reset_outputs(input string name);
    check(name, 64'(|{mem_req, mem_we, mem_addr, mem_wdata, i_rdata, i_rvalid, i_done,
                      d_rdata, d_rvalid, d_done, d_wready, cache_busy}), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1 check_reset_outputs("reset_outputs");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input int max_cyc, input string name);
    int n;
    n = 0;
    while ((i_req || d_req || i_cmd.size() > 0 || d_cmd.size() > 0 || i_exp.size() > 0 ||
            d_exp.size() > 0 || w_exp.size() > 0) && n < max_cyc) begin
      @(negedge clk); n++;
    end
    check({name, "_timeout"}, 64'(n < max_cyc), 64'd1);
    repeat (2) @(negedge clk);
    check({name, "_i_left"}, 64'(i_exp.size()), 64'd0);
    check({name, "_d_left"}, 64'(d_exp.size()), 64'd0);
    check({name, "_w_left"}, 64'(w_exp.size()), 64'd0);
    check({name, "_order_left"}, 64'(order_exp.size()), 64'd0);
  endtask

  task automatic wait_addr(input logic [31:0] a, input string name);
    int n;
    n = 0;
    while (!(mem_req && mem_addr == a) && n < 100) begin @(negedge clk); n++; end
    check(name, 64'(n < 100), 64'd1);
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    dcmd_t c;
    logic [31:0] frozen;
    int k;
    #3 check_reset_outputs("reset_initial");
    @(negedge clk); rst_n = 1'b1;

    // single I refill, memory always ready
    rdy_mode = 0;
    i_cmd.push_back(32'h1000_0014);
    wait_idle(100, "t1_irefill");

    // D writeback with alternating ready
    rdy_mode = 2;
    c.addr = 32'h2000_0000; c.we = 1'b1; d_cmd.push_back(c);
    wait_idle(100, "t3_writeback");

    // async reset during beat 2 of an I refill, then restart from beat 0
    rdy_mode = 0;
    i_cmd.push_back(32'h3000_0008);
    wait_addr(32'h3000_0008, "t4_reach_beat2");
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("t4_reset_outputs");
    i_exp.delete();
    push_reads(1'b1, 32'h3000_0000);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("t4_restart_addr", 64'(mem_addr), 64'h3000_0000);
    wait_idle(100, "t4_restart");

    // memory stall for 20 cycles mid-burst
    c.addr = 32'h4000_0030; c.we = 1'b0; d_cmd.push_back(c);
    wait_addr(32'h4000_0034, "t5_reach_beat1");
    rdy_mode = 3;
    @(negedge clk);
    frozen = mem_addr;
    check("t5_stall_addr_start", 64'(frozen), 64'h4000_0038);
    repeat (20) begin
      @(negedge clk);
      check("t5_stall_req", 64'(mem_req), 64'd1);
      check("t5_stall_addr", 64'(mem_addr), 64'(frozen));
      check("t5_stall_busy", 64'(cache_busy), 64'd1);
      check("t5_stall_nodone", 64'(i_done | d_done), 64'd0);
    end
    rdy_mode = 0;
    wait_idle(100, "t5_resume");

    // simultaneous requests after reset: D first, then I
    do_reset();
    order_exp.push_back(8'h44); order_exp.push_back(8'h49);
    i_cmd.push_back(32'h5000_0000);
    c.addr = 32'h6000_0040; c.we = 1'b0; d_cmd.push_back(c);
    wait_idle(200, "t2a_tie");

    // I held while D re-requests immediately after each done
`ifdef ARB_ROUND_ROBIN_EN
    order_exp.push_back(8'h44); order_exp.push_back(8'h49);
    order_exp.push_back(8'h44); order_exp.push_back(8'h44);
`else
    order_exp.push_back(8'h44); order_exp.push_back(8'h44);
    order_exp.push_back(8'h44); order_exp.push_back(8'h49);
`endif
    i_cmd.push_back(32'h5000_0100);
    for (int j = 0; j < 3; j++) begin
      c.addr = 32'h6000_1000 + 32'(j * 16); c.we = 1'(j & 1); d_cmd.push_back(c);
    end
    wait_idle(300, "t2b_stream");

    // randomized traffic with random memory readiness
    rdy_mode = 1;
    for (int t = 0; t < 30; t++) begin
      k = $urandom_range(0, 3);
      if (k == 0 || k == 3) i_cmd.push_back($urandom);
      if (k >= 1) begin
        c.addr = $urandom; c.we = 1'($urandom_range(0, 1)); d_cmd.push_back(c);
      end
      wait_idle(400, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
